// File: rtl/npu_vec_mac_if.sv
// ----------------------------------------------------------------------------
// npu_vec_mac_if
//   Host access bus of the vector MAC engine (BRAM-style port A).
//
//   Handshake: there is no valid/ready pair. A transfer happens on every
//   rising clk edge where ena=1. wea selects write (1) or read (0). Read data
//   appears on douta the cycle after the read and holds until the next read.
//   The engine never stalls the host, so every access completes in one cycle.
//
//   Signals:
//     ena    host access enable
//     wea    1 = write, 0 = read
//     addra  [14:12] region, [5:4] lane, [3:0] tap
//     dina   write data
//     douta  registered read data
//     done_o window count exhausted and pipeline empty
// ----------------------------------------------------------------------------
interface npu_vec_mac_if;
    logic        ena;
    logic        wea;
    logic [15:0] addra;
    logic [31:0] dina;
    logic [31:0] douta;
    logic        done_o;

    modport master (output ena, wea, addra, dina, input douta, done_o);
    modport slave  (input ena, wea, addra, dina, output douta, done_o);
endinterface

// File: rtl/npu_vec_mac.sv
// ----------------------------------------------------------------------------
// npu_vec_mac
//   Weight-stationary MAC engine. NUM_PE lanes each hold KLEN weights. Beats
//   of NUM_PE activation bytes are popped from an input FIFO. One window is
//   KLEN beats. At the end of a window the lane accumulators are summed,
//   post-processed (raw / ReLU / ReLU+sat255) and queued in a result FIFO
//   that the host reads. The engine runs for N windows after a start.
//
//   Ports:
//     clk        clock
//     rst_ni     asynchronous active-low reset
//     bus        host access bus (slave side), see npu_vec_mac_if
//     dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
//   Host map (addra[14:12]):
//     1 W  push activation beat (byte i -> lane i)
//     2 W  weight[lane][tap] <= dina[7:0]
//     4 W  ctrl: bit0 start, bit1 stop, bit2 clear, [5:4] mode, bit6 act_signed
//     5 W  window count N       5 R  windows remaining
//     6 R  pop result (sign-extended)
//     7 R  status {in_count, out_count, 12'b0, unf, ovf, done, busy}
// ----------------------------------------------------------------------------
module npu_vec_mac #(
    parameter int NUM_PE    = 3,
    parameter int KLEN      = 3,
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 24,
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_ni,
    npu_vec_mac_if.slave       bus,
    output logic [1:0]         dbg_state
);

    localparam int BEAT_W  = NUM_PE * DATA_W;
    localparam int PROD_W  = 2 * DATA_W + 1;
    localparam int IN_AW   = $clog2(IN_DEPTH);
    localparam int OUT_AW  = $clog2(OUT_DEPTH);
    localparam int TAP_W   = (KLEN > 1) ? $clog2(KLEN) : 1;
    localparam int KLEN_M1 = KLEN - 1;

    localparam logic [IN_AW:0]     IN_CAP   = IN_DEPTH[IN_AW:0];
    localparam logic [OUT_AW:0]    OUT_CAP  = OUT_DEPTH[OUT_AW:0];
    localparam logic [TAP_W-1:0]   TAP_LAST = KLEN_M1[TAP_W-1:0];
    localparam logic [ACC_W-1:0]   SAT_MAX  = ACC_W'(255);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // ---------------- host decode ----------------
    logic       host_wr, host_rd;
    logic [2:0] region;
    logic [1:0] lane_idx;
    logic [3:0] tap_idx;
    logic       ctrl_wr, start_p, stop_p, clr_p;
    logic       unused_ok;

    assign host_wr  = bus.ena &  bus.wea;
    assign host_rd  = bus.ena & ~bus.wea;
    assign region   = bus.addra[14:12];
    assign lane_idx = bus.addra[5:4];
    assign tap_idx  = bus.addra[3:0];
    assign ctrl_wr  = host_wr && (region == 3'd4);
    assign start_p  = ctrl_wr && bus.dina[0];
    assign stop_p   = ctrl_wr && bus.dina[1];
    assign clr_p    = ctrl_wr && bus.dina[2];
    assign unused_ok = &{1'b0, bus.addra, bus.dina};

    // ---------------- configuration ----------------
    logic [1:0]  mode;
    logic        act_signed;
    logic [15:0] n_cfg;
    logic [15:0] remaining;
    logic        load_rem;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            mode       <= 2'd0;
            act_signed <= 1'b0;
            n_cfg      <= 16'd0;
        end else begin
            if (ctrl_wr) begin
                mode       <= bus.dina[5:4];
                act_signed <= bus.dina[6];
            end
            if (host_wr && (region == 3'd5)) begin
                n_cfg <= bus.dina[15:0];
            end
        end
    end

    logic signed [DATA_W-1:0] weight [NUM_PE][KLEN];

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int l = 0; l < NUM_PE; l++) begin
                for (int k = 0; k < KLEN; k++) begin
                    weight[l][k] <= '0;
                end
            end
        end else if (host_wr && (region == 3'd2)) begin
            // Loop match keeps out-of-range lane/tap writes harmless.
            for (int l = 0; l < NUM_PE; l++) begin
                for (int k = 0; k < KLEN; k++) begin
                    if ((int'(lane_idx) == l) && (int'(tap_idx) == k)) begin
                        weight[l][k] <= bus.dina[DATA_W-1:0];
                    end
                end
            end
        end
    end

    // ---------------- activation FIFO ----------------
    logic [BEAT_W-1:0] in_mem [IN_DEPTH];
    logic [IN_AW-1:0]  in_wp, in_rp;
    logic [IN_AW:0]    in_count;
    logic              in_empty, in_full, in_push_req, in_push;
    logic [BEAT_W-1:0] in_head;
    logic              eng_pop;

    assign in_empty    = (in_count == '0);
    assign in_full     = (in_count == IN_CAP);
    assign in_push_req = host_wr && (region == 3'd1);
    // A full FIFO still accepts a push when the engine pops the same cycle.
    assign in_push     = in_push_req && (!in_full || eng_pop);
    assign in_head     = in_mem[in_rp];

    always_ff @(posedge clk) begin
        if (in_push) begin
            in_mem[in_wp] <= bus.dina[BEAT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            in_wp    <= '0;
            in_rp    <= '0;
            in_count <= '0;
        end else if (clr_p) begin
            in_wp    <= '0;
            in_rp    <= '0;
            in_count <= '0;
        end else begin
            if (in_push) in_wp <= in_wp + 1'b1;
            if (eng_pop) in_rp <= in_rp + 1'b1;
            case ({in_push, eng_pop})
                2'b10:   in_count <= in_count + 1'b1;
                2'b01:   in_count <= in_count - 1'b1;
                default: in_count <= in_count;
            endcase
        end
    end

    // ---------------- lane datapath ----------------
    logic [ACC_W-1:0]         acc [NUM_PE];
    logic [ACC_W-1:0]         prod [NUM_PE];
    logic [TAP_W-1:0]         tap_cnt;
    logic                     res_valid;   // window sum is being formed this cycle
    logic [DATA_W-1:0]        act_byte;
    logic signed [DATA_W:0]   act_ext;
    logic signed [PROD_W-1:0] prod_full;
    logic [ACC_W-1:0]         acc_sum;
    logic [ACC_W-1:0]         res_postop;

    always_comb begin
        act_byte  = '0;
        act_ext   = '0;
        prod_full = '0;
        for (int l = 0; l < NUM_PE; l++) begin
            act_byte  = in_head[l*DATA_W +: DATA_W];
            act_ext   = {act_signed & act_byte[DATA_W-1], act_byte};
            prod_full = PROD_W'(act_ext) * PROD_W'(weight[l][tap_cnt]);
            prod[l]   = ACC_W'(prod_full);
        end
    end

    always_comb begin
        acc_sum = '0;
        for (int l = 0; l < NUM_PE; l++) begin
            acc_sum = acc_sum + acc[l];
        end
    end

    always_comb begin
        res_postop = acc_sum;
        case (mode)
            2'd1: begin
                if (acc_sum[ACC_W-1]) res_postop = '0;
            end
            2'd2: begin
                if (acc_sum[ACC_W-1])       res_postop = '0;
                else if (acc_sum > SAT_MAX) res_postop = SAT_MAX;
            end
            default: res_postop = acc_sum;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int l = 0; l < NUM_PE; l++) acc[l] <= '0;
            tap_cnt   <= '0;
            res_valid <= 1'b0;
        end else if (clr_p) begin
            for (int l = 0; l < NUM_PE; l++) acc[l] <= '0;
            tap_cnt   <= '0;
            res_valid <= 1'b0;
        end else begin
            // While the finished window is summed, a new first tap starts
            // from zero instead of the stale accumulator.
            for (int l = 0; l < NUM_PE; l++) begin
                if (eng_pop)        acc[l] <= (res_valid ? '0 : acc[l]) + prod[l];
                else if (res_valid) acc[l] <= '0;
            end
            if (eng_pop) begin
                tap_cnt   <= (tap_cnt == TAP_LAST) ? '0 : tap_cnt + 1'b1;
                res_valid <= (tap_cnt == TAP_LAST);
            end else begin
                res_valid <= 1'b0;
            end
        end
    end

    // ---------------- result FIFO ----------------
    logic [ACC_W-1:0]  out_mem [OUT_DEPTH];
    logic [OUT_AW-1:0] out_wp, out_rp;
    logic [OUT_AW:0]   out_count;
    logic              out_empty, out_full, out_push, out_pop, host_pop_req;
    logic              out_room, win_left;

    assign out_empty    = (out_count == '0);
    assign out_full     = (out_count == OUT_CAP);
    assign host_pop_req = host_rd && (region == 3'd6);
    assign out_pop      = host_pop_req && !out_empty;
    assign out_push     = res_valid && !clr_p && (!out_full || out_pop);

    // The window being summed already owns a result slot, so it is counted.
    assign out_room = (out_count + {{OUT_AW{1'b0}}, res_valid}) < OUT_CAP;
    // Do not start beats of a window beyond the programmed count.
    assign win_left = remaining > {15'b0, res_valid};
    assign eng_pop  = (state == S_RUN) && !in_empty && win_left && out_room;

    always_ff @(posedge clk) begin
        if (out_push) begin
            out_mem[out_wp] <= res_postop;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            out_wp    <= '0;
            out_rp    <= '0;
            out_count <= '0;
        end else if (clr_p) begin
            out_wp    <= '0;
            out_rp    <= '0;
            out_count <= '0;
        end else begin
            if (out_push) out_wp <= out_wp + 1'b1;
            if (out_pop)  out_rp <= out_rp + 1'b1;
            case ({out_push, out_pop})
                2'b10:   out_count <= out_count + 1'b1;
                2'b01:   out_count <= out_count - 1'b1;
                default: out_count <= out_count;
            endcase
        end
    end

    // ---------------- window count and sticky flags ----------------
    logic ovf, unf;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            remaining <= 16'd0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else if (clr_p) begin
            remaining <= 16'd0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            if (load_rem)                            remaining <= n_cfg;
            else if (res_valid && (remaining != '0)) remaining <= remaining - 1'b1;
            if (in_push_req && !in_push) ovf <= 1'b1;
            if (host_pop_req && out_empty) unf <= 1'b1;
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_rem  = 1'b0;
        if (clr_p) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_p) begin
                        if (n_cfg == '0) begin
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_RUN;
                            // A stopped run resumes; a fresh run reloads.
                            load_rem  = (remaining == '0);
                        end
                    end
                end
                S_RUN: begin
                    if (stop_p)
                        state_nxt = S_IDLE;
                    else if ((remaining == '0) && !res_valid)
                        state_nxt = S_DONE;
                end
                S_DONE: begin
                    if (start_p && (n_cfg != '0)) begin
                        state_nxt = S_RUN;
                        load_rem  = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- host read port ----------------
    logic        done_w, busy_w;
    logic [31:0] status_w;

    assign done_w    = (state == S_DONE);
    assign busy_w    = (state == S_RUN);
    assign status_w  = {8'(in_count), 8'(out_count), 12'b0, unf, ovf, done_w, busy_w};
    assign bus.done_o = done_w;
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.douta <= 32'd0;
        end else if (host_rd) begin
            case (region)
                3'd5:    bus.douta <= {16'd0, remaining};
                3'd6:    bus.douta <= out_empty ? 32'd0 : 32'($signed(out_mem[out_rp]));
                3'd7:    bus.douta <= status_w;
                default: bus.douta <= 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_npu_vec_mac.sv
// ----------------------------------------------------------------------------
// tb_npu_vec_mac
//   Directed bench for npu_vec_mac (NUM_PE=3, KLEN=3, OUT_DEPTH=8).
//   Table of single-window vectors plus hand-written multi-cycle sequences.
// ----------------------------------------------------------------------------
module tb_npu_vec_mac;

    localparam logic [2:0] R_ACT = 3'd1, R_WGT = 3'd2, R_CTRL = 3'd4;
    localparam logic [2:0] R_NWIN = 3'd5, R_RES = 3'd6, R_STAT = 3'd7;
    localparam logic [2:0] P_START = 3'b001, P_STOP = 3'b010, P_CLEAR = 3'b100;

    logic       clk;
    logic       rst_ni;
    logic [1:0] dbg_state;

    npu_vec_mac_if bus ();

    npu_vec_mac dut (
        .clk       (clk),
        .rst_ni    (rst_ni),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        string       name;
        logic [23:0] w;       // weight byte per lane, same for all taps
        logic [23:0] b0, b1, b2;
        logic        sgn;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    vec_t vq[$];

    // ---------------- helpers ----------------
    function automatic logic [15:0] mk_addr(input logic [2:0] region,
                                            input logic [1:0] lane,
                                            input logic [3:0] tap);
        return {1'b0, region, 6'b0, lane, tap};
    endfunction

    function automatic logic [31:0] mk_ctrl(input logic sgn, input logic [1:0] mode,
                                            input logic [2:0] pulse);
        return {25'b0, sgn, mode, 1'b0, pulse};
    endfunction

    function automatic vec_t mk_vec(input string name, input logic [23:0] w,
                                    input logic [23:0] b0, input logic [23:0] b1,
                                    input logic [23:0] b2, input logic sgn,
                                    input logic [1:0] mode, input logic [31:0] exp);
        vec_t v;
        v.name = name; v.w = w; v.b0 = b0; v.b1 = b1; v.b2 = b2;
        v.sgn = sgn; v.mode = mode; v.exp = exp;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic host_wr(input logic [15:0] a, input logic [31:0] d);
        bus.ena = 1'b1; bus.wea = 1'b1; bus.addra = a; bus.dina = d;
        @(posedge clk); #1;
        bus.ena = 1'b0; bus.wea = 1'b0;
    endtask

    task automatic host_rd(input logic [15:0] a, output logic [31:0] d);
        bus.ena = 1'b1; bus.wea = 1'b0; bus.addra = a;
        @(posedge clk); #1;
        bus.ena = 1'b0;
        d = bus.douta;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_lane_weights(input logic [23:0] w);
        for (int l = 0; l < 3; l++)
            for (int k = 0; k < 3; k++)
                host_wr(mk_addr(R_WGT, l[1:0], k[3:0]), {24'b0, w[l*8 +: 8]});
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (bus.done_o !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check32(name, {31'b0, bus.done_o}, 32'd1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rd;

        bus.ena = 1'b0; bus.wea = 1'b0; bus.addra = '0; bus.dina = '0;
        rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        idle(1);

        // Reset state
        check32("reset_douta", bus.douta, 32'd0);
        check32("reset_done", {31'b0, bus.done_o}, 32'd0);
        check32("reset_state", {30'b0, dbg_state}, 32'd0);
        host_rd(mk_addr(R_STAT, 2'd0, 4'd0), rd);
        check32("reset_status", rd, 32'd0);
        host_rd(mk_addr(R_NWIN, 2'd0, 4'd0), rd);
        check32("reset_remaining", rd, 32'd0);

        // Identity window with cycle-exact latency
        set_lane_weights(24'h010101);
        host_wr(mk_addr(R_NWIN, 2'd0, 4'd0), 32'd1);
        for (int i = 0; i < 3; i++) host_wr(mk_addr(R_ACT, 2'd0, 4'd0), 32'h00030201);
        host_wr(mk_addr(R_CTRL, 2'd0, 4'd0), mk_ctrl(1'b0, 2'd0, P_START));
        idle(3);
        host_rd(mk_addr(R_STAT, 2'd0, 4'd0), rd);
        check32("ident_stat_before_push", rd, 32'h0000_0001);
        host_rd(mk_addr(R_STAT, 2'd0, 4'd0), rd);
        check32("ident_stat_t_plus_2", rd, 32'h0001_0001);
        host_rd(mk_addr(R_STAT, 2'd0, 4'd0), rd);
        check32("ident_stat_done", rd, 32'h0001_0002);
        check32("ident_done_o", {31'b0, bus.done_o}, 32'd1);
        host_rd(mk_addr(R_RES, 2'd0, 4'd0), rd);
        check32("ident_result", rd, 32'd18);

        // Table of single-window vectors
        vq.push_back(mk_vec("v_identity",   24'h010101, 24'h030201, 24'h030201, 24'h030201, 1'b0, 2'd0, 32'd18));
        vq.push_back(mk_vec("v_unsigned_ff",24'hFEFEFE, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 2'd0, 32'hFFFF_EE12));
        vq.push_back(mk_vec("v_signed_ff",  24'hFEFEFE, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 2'd0, 32'd18));
        vq.push_back(mk_vec("v_m5_raw",     24'h0000FF, 24'h000001, 24'h000002, 24'h000002, 1'b0, 2'd0, 32'hFFFF_FFFB));
        vq.push_back(mk_vec("v_m5_relu",    24'h0000FF, 24'h000001, 24'h000002, 24'h000002, 1'b0, 2'd1, 32'd0));
        vq.push_back(mk_vec("v_m5_sat",     24'h0000FF, 24'h000001, 24'h000002, 24'h000002, 1'b0, 2'd2, 32'd0));
        vq.push_back(mk_vec("v_m5_mode3",   24'h0000FF, 24'h000001, 24'h000002, 24'h000002, 1'b0, 2'd3, 32'hFFFF_FFFB));
        vq.push_back(mk_vec("v_300_raw",    24'h000064, 24'h000001, 24'h000001, 24'h000001, 1'b0, 2'd0, 32'd300));
        vq.push_back(mk_vec("v_300_relu",   24'h000064, 24'h000001, 24'h000001, 24'h000001, 1'b0, 2'd1, 32'd300));
        vq.push_back(mk_vec("v_300_sat",    24'h000064, 24'h000001, 24'h000001, 24'h000001, 1'b0, 2'd2, 32'd255));
        vq.push_back(mk_vec("v_mixed_s",    24'h037F80, 24'h0510FF, 24'h0510FF, 24'h0510FF, 1'b1, 2'd0, 32'h0000_197D));
        vq.push_back(mk_vec("v_mixed_u",    24'h037F80, 24'h0510FF, 24'h0510FF, 24'h0510FF, 1'b0, 2'd0, 32'hFFFE_997D));

        foreach (vq[i]) begin
            host_wr(mk_addr(R_CTRL, 2'd0, 4'd0), mk_ctrl(vq[i].sgn, vq[i].mode, P_CLEAR));
            set_lane_weights(vq[i].w);
            host_wr(mk_addr(R_NWIN, 2'd0, 4'd0), 32'd1);
            host_wr(mk_addr(R_ACT, 2'd0, 4'd0), {8'b0, vq[i].b0});
            host_wr(mk_addr(R_ACT, 2'd0, 4'd0), {8'b0, vq[i].b1});
            host_wr(mk_addr(R_ACT, 2'd0, 4'd0), {8'b0, vq[i].b2});
            host_wr(mk_addr(R_CTRL, 2'd0, 4'd0), mk_ctrl(vq[i].sgn, vq[i].mode, P_START));
            wait_done(50, {vq[i].name, "_done"});
            host_rd(mk_addr(R_RES, 2'd0, 4'd0), rd);
            check32(vq[i].name, rd, vq[i].exp);
        end

        // Backpressure: 12 windows, no reads until the result FIFO fills
        host_wr(mk_addr(R_CTRL, 2'd0, 4'd0), mk_ctrl(1'b0, 2'd0, P_CLEAR));
        set_lane_weights(24'h010101);
        host_wr(mk_addr(R_NWIN, 2'd0, 4'd0), 32'd12);
        host_wr(mk_addr(R_CTRL, 2'd0, 4'd0), mk_ctrl(1'b0, 2'd0, P_START));
        for (int k = 0; k < 12; k++) begin
            logic [23:0] beat;
            beat = 24'h010101 * 24'(k + 1);
            exp_q.push_back(32'(9 * (k + 1)));
            for (int t = 0; t < 3; t++) host_wr(mk_addr(R_ACT, 2'd0, 4'd0), {8'b0, beat});
        end
        idle(4);
        host_rd(mk_addr(R_STAT, 2'd0, 4'd0), rd);
        check32("bp_stalled_status", rd, 32'h0C08_0001);
        for (int i = 0; i < 4; i++) begin
            host_rd(mk_addr(R_RES, 2'd0, 4'd0), rd);
            check32("bp_result_first4", rd, exp_q.pop_front());
        end
        wait_done(200, "bp_done");
        host_rd(mk_addr(R_STAT, 2'd0, 4'd0), rd);
        check32("bp_final_status", rd, 32'h0008_0002);
        while (exp_q.size() != 0) begin
            host_rd(mk_addr(R_RES, 2'd0, 4'd0), rd);
            check32("bp_result_rest", rd, exp_q.pop_front());
        end

        // Boundaries: overflow, underflow, clear
        host_wr(mk_addr(R_CTRL, 2'd0, 4'd0), mk_ctrl(1'b0, 2'd0, P_CLEAR));
        for (int i = 0; i < 17; i++) host_wr(mk_addr(R_ACT, 2'd0, 4'd0), 32'(i));
        host_rd(mk_addr(R_STAT, 2'd0, 4'd0), rd);
        check32("ovf_status", rd, 32'h1000_0004);
        host_rd(mk_addr(R_RES, 2'd0, 4'd0), rd);
        check32("unf_read_zero", rd, 32'd0);
        host_rd(mk_addr(R_STAT, 2'd0, 4'd0), rd);
        check32("unf_status", rd, 32'h1000_000C);
        host_wr(mk_addr(R_CTRL, 2'd0, 4'd0), mk_ctrl(1'b0, 2'd0, P_CLEAR));
        host_rd(mk_addr(R_STAT, 2'd0, 4'd0), rd);
        check32("clear_status", rd, 32'd0);

        // Stop after one tap, then resume
        host_wr(mk_addr(R_NWIN, 2'd0, 4'd0), 32'd1);
        host_wr(mk_addr(R_ACT, 2'd0, 4'd0), 32'h0001_0203);
        host_wr(mk_addr(R_CTRL, 2'd0, 4'd0), mk_ctrl(1'b0, 2'd0, P_START));
        host_wr(mk_addr(R_CTRL, 2'd0, 4'd0), mk_ctrl(1'b0, 2'd0, P_STOP));
        host_wr(mk_addr(R_ACT, 2'd0, 4'd0), 32'h0004_0404);
        host_wr(mk_addr(R_ACT, 2'd0, 4'd0), 32'h0005_0505);
        idle(3);
        host_rd(mk_addr(R_STAT, 2'd0, 4'd0), rd);
        check32("stop_status", rd, 32'h0200_0000);
        host_wr(mk_addr(R_CTRL, 2'd0, 4'd0), mk_ctrl(1'b0, 2'd0, P_START));
        wait_done(50, "resume_done");
        host_rd(mk_addr(R_RES, 2'd0, 4'd0), rd);
        check32("resume_result", rd, 32'd33);

        // Start with N=0 goes straight to DONE
        host_wr(mk_addr(R_CTRL, 2'd0, 4'd0), mk_ctrl(1'b0, 2'd0, P_CLEAR));
        host_wr(mk_addr(R_NWIN, 2'd0, 4'd0), 32'd0);
        host_wr(mk_addr(R_CTRL, 2'd0, 4'd0), mk_ctrl(1'b0, 2'd0, P_START));
        check32("n0_done_o", {31'b0, bus.done_o}, 32'd1);
        check32("n0_state", {30'b0, dbg_state}, 32'd2);

        // Asynchronous reset while running
        host_wr(mk_addr(R_CTRL, 2'd0, 4'd0), mk_ctrl(1'b0, 2'd0, P_CLEAR));
        host_wr(mk_addr(R_NWIN, 2'd0, 4'd0), 32'd5);
        host_wr(mk_addr(R_CTRL, 2'd0, 4'd0), mk_ctrl(1'b0, 2'd0, P_START));
        check32("run_state", {30'b0, dbg_state}, 32'd1);
        host_rd(mk_addr(R_NWIN, 2'd0, 4'd0), rd);
        check32("run_remaining", rd, 32'd5);
        host_rd(mk_addr(R_STAT, 2'd0, 4'd0), rd);
        check32("run_status", rd, 32'h0000_0001);
        #2 rst_ni = 1'b0;
        #1;
        check32("arst_douta", bus.douta, 32'd0);
        check32("arst_state", {30'b0, dbg_state}, 32'd0);
        check32("arst_done", {31'b0, bus.done_o}, 32'd0);
        #1 rst_ni = 1'b1;
        idle(1);
        host_rd(mk_addr(R_STAT, 2'd0, 4'd0), rd);
        check32("post_rst_status", rd, 32'd0);
        host_rd(mk_addr(R_NWIN, 2'd0, 4'd0), rd);
        check32("post_rst_remaining", rd, 32'd0);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
